controlpa20: RTL and testbench

Sequencing controller for the 20-band-pass biquad datapath (`filtropa20`). On each sample strobe it walks the datapath through a fixed five-step multiply-accumulate program:
- computes f(k) = u(k) − a1·f(k−1) − a2·f(k−2);
- computes y(k) = b0·f(k) − b0·f(k−2);
- shifts the f history;
- flags completion.

It sits between the ADC sample-strobe logic and `filtropa20`, driving every register enable and mux select of that datapath.

---
 rtl/controlpa20_if.sv | 41 ++++
 rtl/controlpa20.sv | 133 +++++++++++++
 tb/tb_controlpa20.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlpa20_if.sv
// Control bundle between controlpa20 and the filtropa20 datapath / sample-strobe logic.
// Optional overrun flag exists only when CTRL_PA20_OVERRUN_EN is defined.
interface controlpa20_if;
    // start is a one-cycle strobe, accepted only while busy is low; done pulses once per accepted start.
    logic       start;
    logic       en1;
    logic       en2;
    logic       en3;
    logic       en4;
    logic       en5;
    logic       en6;
    logic       en7;
    logic [2:0] selmuxS;
    logic [1:0] selmuxC;
    logic [2:0] selmuxZ;
    logic       busy;
    logic       done;
`ifdef CTRL_PA20_OVERRUN_EN
    logic       overrun;
`endif

    modport master (
        input  start,
        output en1, en2, en3, en4, en5, en6, en7,
        output selmuxS, selmuxC, selmuxZ,
`ifdef CTRL_PA20_OVERRUN_EN
        output overrun,
`endif
        output busy, done
    );

    modport slave (
        output start,
        input  en1, en2, en3, en4, en5, en6, en7,
        input  selmuxS, selmuxC, selmuxZ,
`ifdef CTRL_PA20_OVERRUN_EN
        input  overrun,
`endif
        input  busy, done
    );
endinterface

// File: rtl/controlpa20.sv
// Five-step MAC sequencer for the filtropa20 biquad datapath (Moore FSM).
// Define CTRL_PA20_OVERRUN_EN to add the sticky overrun flag.
module controlpa20 (
    input  logic             clk,
    input  logic             reset,
    controlpa20_if.master    bus,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC1  = 3'd1,
        MAC2  = 3'd2,
        MAC3  = 3'd3,
        MAC4  = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [6:0] en;
    logic [2:0] sel_s;
    logic [1:0] sel_c;
    logic [2:0] sel_z;
    logic       busy;
    logic       done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bus.start ? MAC1 : IDLE;
            MAC1:    state_d = MAC2;
            MAC2:    state_d = MAC3;
            MAC3:    state_d = MAC4;
            MAC4:    state_d = SHIFT;
            SHIFT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // en[0] is en1 (Y(k)) ... en[6] is en7 (acum3); the unused encoding falls to all-zero.
    always_comb begin
        en    = 7'b0;
        sel_s = 3'd0;
        sel_c = 2'd0;
        sel_z = 3'd0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            MAC1: begin
                en[4] = 1'b1;
                sel_s = 3'd1;
                sel_c = 2'd0;
                sel_z = 3'd1;
                busy  = 1'b1;
            end
            MAC2: begin
                en[1] = 1'b1;
                en[5] = 1'b1;
                sel_s = 3'd2;
                sel_c = 2'd1;
                sel_z = 3'd2;
                busy  = 1'b1;
            end
            MAC3: begin
                en[6] = 1'b1;
                sel_s = 3'd0;
                sel_c = 2'd2;
                sel_z = 3'd0;
                busy  = 1'b1;
            end
            MAC4: begin
                en[0] = 1'b1;
                sel_s = 3'd2;
                sel_c = 2'd3;
                sel_z = 3'd4;
                busy  = 1'b1;
            end
            SHIFT: begin
                en[2] = 1'b1;
                en[3] = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                en = 7'b0;
            end
        endcase
    end

`ifdef CTRL_PA20_OVERRUN_EN
    logic overrun_q;

    // A strobe while a sample is in flight is dropped, but remembered until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (bus.start && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`endif

    assign bus.en1     = en[0];
    assign bus.en2     = en[1];
    assign bus.en3     = en[2];
    assign bus.en4     = en[3];
    assign bus.en5     = en[4];
    assign bus.en6     = en[5];
    assign bus.en7     = en[6];
    assign bus.selmuxS = sel_s;
    assign bus.selmuxC = sel_c;
    assign bus.selmuxZ = sel_z;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign state_o     = state_q;

endmodule

// File: tb/tb_controlpa20.sv
// Directed and randomized bench for controlpa20, driving a Q8 fixed-point stand-in for filtropa20.
// Expected filter outputs come from the plain biquad recurrence, not from the control table.
module tb_controlpa20;

    logic       clk;
    logic       reset;
    logic [2:0] state_o;
    int         n_checks;
    int         n_fail;

    controlpa20_if bus ();

    controlpa20 dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- datapath stand-in (Q8) ----------------
    int uk_r;
    int na1, na2, b0;
    int yk_r, fk_r, fk1_r, fk2_r, ac1_r, ac2_r, ac3_r;
    int s_v, c_v, z_v, res_v;

    always_comb begin
        s_v = 0;
        c_v = 0;
        z_v = 0;
        case (bus.selmuxS)
            3'd0: s_v = fk_r;
            3'd1: s_v = fk1_r;
            3'd2: s_v = fk2_r;
            3'd3: s_v = yk_r;
            3'd4: s_v = uk_r;
            default: s_v = 0;
        endcase
        case (bus.selmuxC)
            2'd0: c_v = na1;
            2'd1: c_v = na2;
            2'd2: c_v = b0;
            default: c_v = -b0;
        endcase
        case (bus.selmuxZ)
            3'd1: z_v = uk_r;
            3'd2: z_v = ac1_r;
            3'd3: z_v = ac2_r;
            3'd4: z_v = ac3_r;
            default: z_v = 0;
        endcase
        res_v = ((s_v * c_v) >>> 8) + z_v;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            yk_r  <= 0;
            fk_r  <= 0;
            fk1_r <= 0;
            fk2_r <= 0;
            ac1_r <= 0;
            ac2_r <= 0;
            ac3_r <= 0;
        end else begin
            if (bus.en1) yk_r  <= res_v;
            if (bus.en2) fk_r  <= res_v;
            if (bus.en3) fk1_r <= fk_r;
            if (bus.en4) fk2_r <= fk1_r;
            if (bus.en5) ac1_r <= res_v;
            if (bus.en6) ac2_r <= res_v;
            if (bus.en7) ac3_r <= res_v;
        end
    end

    // ---------------- reference model ----------------
    int m_f, m_y, m_f1, m_f2;

    function automatic int mulq(input int a, input int b);
        return (a * b) >>> 8;
    endfunction

    task automatic model_sample(input int u);
        m_f  = u + mulq(na1, m_f1) + mulq(na2, m_f2);
        m_y  = mulq(b0, m_f) - mulq(b0, m_f2);
        m_f2 = m_f1;
        m_f1 = m_f;
    endtask

    task automatic model_reset();
        m_f  = 0;
        m_y  = 0;
        m_f1 = 0;
        m_f2 = 0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs_vec();
        return {bus.en7, bus.en6, bus.en5, bus.en4, bus.en3, bus.en2, bus.en1,
                bus.selmuxS, bus.selmuxC, bus.selmuxZ, bus.busy, bus.done};
    endfunction

    task automatic chk_datapath(input string tag);
        chk({tag, ".yk"},  yk_r,  m_y);
        chk({tag, ".fk"},  fk_r,  m_f);
        chk({tag, ".fk1"}, fk1_r, m_f1);
        chk({tag, ".fk2"}, fk2_r, m_f2);
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sample(input int u, input string tag);
        bit seen;
        uk_r = u;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else step();
        end
        chk({tag, ".done_seen"}, seen, 1'b1);
        model_sample(u);
        chk_datapath(tag);
        step();
    endtask

    // ---------------- stimulus ----------------
    logic [16:0] exp_tab [0:7];
    logic [20:0] done_hist;
    logic [20:0] done_exp;
    int          done_cnt;
    int          done_cyc;

    initial begin
        exp_tab[0] = 17'd0;
        exp_tab[1] = {7'b0010000, 3'd1, 2'd0, 3'd1, 1'b1, 1'b0};
        exp_tab[2] = {7'b0100010, 3'd2, 2'd1, 3'd2, 1'b1, 1'b0};
        exp_tab[3] = {7'b1000000, 3'd0, 2'd2, 3'd0, 1'b1, 1'b0};
        exp_tab[4] = {7'b0000001, 3'd2, 2'd3, 3'd4, 1'b1, 1'b0};
        exp_tab[5] = {7'b0001100, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0};
        exp_tab[6] = {7'b0000000, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1};
        exp_tab[7] = 17'd0;

        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        uk_r      = 0;
        na1       = 128;
        na2       = 0;
        b0        = 256;
        model_reset();

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.outputs", obs_vec(), 17'd0);
        chk("reset.state", state_o, 3'd0);
`ifdef CTRL_PA20_OVERRUN_EN
        chk("reset.overrun", bus.overrun, 1'b0);
`endif
        reset = 1'b1;
        step();
        step();
        chk("idle.hold", obs_vec(), 17'd0);

        // Single start pulse, checked cycle by cycle; first sample uk=1.0
        uk_r = 256;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("vec.cycle%0d", k), obs_vec(), exp_tab[k]);
            if (k == 6) begin
                model_sample(256);
                chk_datapath("sample1");
                chk("sample1.yk_is_1.0", yk_r, 256);
            end
            if (k < 7) step();
        end

        // Second and third samples with uk=0
        run_sample(0, "sample2");
        chk("sample2.yk_is_0.5", yk_r, 128);
        run_sample(0, "sample3");
        chk("sample3.yk_is_-0.75", yk_r, -192);

        // Reset mid-sequence while in MAC3
        uk_r = 512;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("midrst.pre_mac3", obs_vec(), exp_tab[3]);
        reset = 1'b0;
        #1;
        chk("midrst.outputs", obs_vec(), 17'd0);
        chk("midrst.state", state_o, 3'd0);
        model_reset();
        chk("midrst.fk1", fk1_r, 0);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("midrst.quiet", obs_vec(), 17'd0);
        chk("midrst.quiet_state", state_o, 3'd0);

        // Start pulses at cycles 0 and 3: one sequence only
        uk_r = 256;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = k;
                model_sample(256);
                chk_datapath("overlap");
            end
`ifdef CTRL_PA20_OVERRUN_EN
            if (k >= 4) chk($sformatf("overlap.overrun%0d", k), bus.overrun, 1'b1);
            else        chk($sformatf("overlap.overrun%0d", k), bus.overrun, 1'b0);
`endif
            if (k == 3) bus.start = 1'b1;
            step();
            bus.start = 1'b0;
        end
        chk("overlap.done_count", done_cnt, 1);
        chk("overlap.done_cycle", done_cyc, 6);

        // start held high for 20 cycles
        uk_r = 64;
        bus.start = 1'b1;
        done_hist = '0;
        done_exp  = '0;
        done_exp[6]  = 1'b1;
        done_exp[13] = 1'b1;
        done_exp[20] = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            done_hist[k] = bus.done;
            if (k == 20) bus.start = 1'b0;
            if (k < 20) step();
        end
        chk("held.done_pattern", done_hist, done_exp);
        chk("held.no_adjacent", |(done_hist & (done_hist >> 1)), 1'b0);
        for (int k = 0; k < 3; k++) model_sample(64);
        chk_datapath("held");
        step();
        chk("held.back_idle", obs_vec(), 17'd0);

        // Randomized samples with a non-zero a2 term
        na2 = -64;
        for (int n = 0; n < 10; n++) begin
            run_sample($signed($urandom_range(4096, 0)) - 2048, $sformatf("rand%0d", n));
            repeat ($urandom_range(3, 0)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
